divmod_seq: RTL and testbench
=============================

Name: divmod_seq

Overview:
- Multi-cycle unsigned integer divider for the 16-bit CPU ALU.
- Produces quotient and remainder (MOD) for the ALU result mux and the write-back stage.
- Replaces the loop-based combinational modulo path with a synthesizable restoring divider that computes one bit per clock.
- Start/Busy/Done handshake lets the control unit stall the pipeline while the operation runs.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only when the block is accepting (see Behaviour).
- Hyrja1  input  WIDTH  dividend A; captured on the accepted Start edge.
- Hyrja2  input  WIDTH  divisor B; captured on the accepted Start edge.
- Busy  output  1  high while an iteration is in progress.
- Done  output  1  one-cycle pulse; results are valid from this cycle.
- Heresi  output  WIDTH  quotient A / B.
- Mbetja  output  WIDTH  remainder A % B.
- DivZero  output  1  high with results when B was 0; held with the results.

Behaviour:
- One clock domain (Clock). Reset is synchronous and active-high, and has priority over every other input.
- Reset values: state=IDLE, Busy=0, Done=0, Heresi=0, Mbetja=0, DivZero=0, counter=0, internal registers=0.
- States:
  - IDLE: Busy=0, Done=0.
  - CALC: Busy=1, Done=0.
  - DONE: Busy=0, Done=1.
- Start is accepted only in IDLE or DONE. Start in CALC is ignored and has no side effects.
- Accepted Start with Hyrja2≠0:
  - Latch divisor and dividend.
  - Clear the partial remainder; counter=WIDTH; go to CALC.
- Accepted Start with Hyrja2=0:
  - Go directly to DONE next cycle.
  - Heresi = all ones, Mbetja = Hyrja1, DivZero=1.
  - Busy never asserts.
- Each CALC cycle performs one restoring step:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Compute trial = rem − divisor at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and quotient LSB=1; else quotient LSB=0.
  - Decrement counter. Leave CALC for DONE when the counter reaches 1 at the edge.
- Latency: Start accepted at edge k gives Busy=1 in cycles k+1 … k+WIDTH and Done=1 in cycle k+WIDTH+1 (17 cycles for WIDTH=16).
- Divide-by-zero latency: Done in cycle k+1.
- Results: Heresi, Mbetja and DivZero are registered. They update only on entry to DONE and hold until the next entry to DONE or Reset. They do not change while CALC runs.
- DivZero is cleared on entry to DONE for any non-zero divisor.
- DONE lasts exactly one cycle, then:
  - Start high in that cycle begins a new operation (back-to-back; Done does not re-pulse).
  - Otherwise go to IDLE.
- Operands are sampled only at acceptance. Changes to Hyrja1/Hyrja2 during CALC have no effect.
- Reset asserted mid-CALC: the operation is aborted next edge, all outputs return to reset values, and no Done is produced.
- Edge cases:
  - A < B gives Heresi=0, Mbetja=A.
  - A=0 gives Heresi=0, Mbetja=0.
  - A = B = max gives Heresi=1, Mbetja=0.
  - No signed handling: operands are unsigned only.

Test Plan:
- Basic divide: A=100, B=7, Start for 1 cycle.
  - Busy high for 16 cycles, then Done for 1 cycle.
  - Heresi=14, Mbetja=2, DivZero=0; values held while in IDLE.
- Boundary divides:
  - 65535/1 gives Q=65535, R=0.
  - 5/9 gives Q=0, R=5.
  - 65535/65535 gives Q=1, R=0.
  - 0/3 gives Q=0, R=0.
- Divide by zero: A=1234, B=0.
  - Done one cycle after Start, Busy never high.
  - Heresi=0xFFFF, Mbetja=1234, DivZero=1.
  - A following 10/3 clears DivZero and gives Q=3, R=1.
- Start ignored while busy: start 1000/10, pulse Start with A=7, B=2 at cycle 5 of CALC.
  - Result is Q=100, R=0, Done at cycle 17 only.
  - Operand changes during CALC likewise have no effect.
- Back-to-back: hold Start high during the Done cycle with A=50, B=6.
  - Busy high next cycle; second Done 17 cycles later with Q=8, R=2.
  - Results stay Q/R of the first operation until the second Done.
- Reset mid-operation: assert Reset at cycle 8 of 300/7.
  - All outputs 0 next cycle and no Done appears.
  - A fresh 300/7 afterwards gives Q=42, R=6.

Source files
------------

// File: rtl/divmod_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface divmod_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] Hyrja1;
  logic [WIDTH-1:0] Hyrja2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Heresi;
  logic [WIDTH-1:0] Mbetja;
  logic             DivZero;

  // Control unit side: issues requests, consumes results.
  modport master (
    output Start, Hyrja1, Hyrja2,
    input  Busy, Done, Heresi, Mbetja, DivZero
  );

  // Divider side.
  modport slave (
    input  Start, Hyrja1, Hyrja2,
    output Busy, Done, Heresi, Mbetja, DivZero
  );
endinterface

// File: rtl/divmod_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
module divmod_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  divmod_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StCalc = 2'd1, StDone = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the dividend at start; quotient bits shift in from the LSB as it drains.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] heresi_q, heresi_d;
  logic [WIDTH-1:0] mbetja_q, mbetja_d;
  logic             divzero_q, divzero_d;

  logic             accept;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             unused_trial;

  // One restoring step; trial carries an extra sign bit since rem_sh can reach 2*divisor-1.
  always_comb begin
    rem_sh       = {rem_q, quo_q[WIDTH-1]};
    trial        = {1'b0, rem_sh} - {2'b00, div_q};
    trial_ok     = ~trial[WIDTH+1];
    r_step       = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_step       = {quo_q[WIDTH-2:0], trial_ok};
    unused_trial = trial[WIDTH];
  end

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    heresi_d  = heresi_q;
    mbetja_d  = mbetja_q;
    divzero_d = divzero_q;
    accept    = ((state_q == StIdle) || (state_q == StDone)) && bus.Start;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (bus.Hyrja2 == '0) begin
            state_d   = StDone;
            heresi_d  = '1;
            mbetja_d  = bus.Hyrja1;
            divzero_d = 1'b1;
          end else begin
            state_d = StCalc;
            div_d   = bus.Hyrja2;
            quo_d   = bus.Hyrja1;
            rem_d   = '0;
            cnt_d   = CNTW'(WIDTH);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        rem_d = r_step;
        quo_d = q_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d   = StDone;
          heresi_d  = q_step;
          mbetja_d  = r_step;
          divzero_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      heresi_q  <= '0;
      mbetja_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      heresi_q  <= heresi_d;
      mbetja_q  <= mbetja_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.Busy    = (state_q == StCalc);
  assign bus.Done    = (state_q == StDone);
  assign bus.Heresi  = heresi_q;
  assign bus.Mbetja  = mbetja_q;
  assign bus.DivZero = divzero_q;

endmodule

// File: tb/tb_divmod_seq.sv
// Directed self-checking bench for divmod_seq.
module tb_divmod_seq;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   busy_n;
  int   done_seen;

  divmod_seq_if #(.WIDTH(WIDTH)) bus ();

  divmod_seq #(.WIDTH(WIDTH), .CNTW(5)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive Start for one cycle; returns at the negedge of the first cycle after acceptance.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.Start  = 1'b1;
    bus.Hyrja1 = a;
    bus.Hyrja2 = b;
    @(negedge clk);
    bus.Start  = 1'b0;
  endtask

  // Bounded wait for Done; c is the current cycle index after acceptance.
  task automatic wait_done(input int c0, output int c, output int nbusy);
    c     = c0;
    nbusy = 0;
    while (!bus.Done && c < 40) begin
      if (bus.Busy) nbusy++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic edz, input int ecyc);
    int c;
    int nb;
    start_op(a, b);
    wait_done(1, c, nb);
    chk({tag, ".done"}, 32'(bus.Done), 32'd1);
    chk({tag, ".lat"}, 32'(c), 32'(ecyc));
    chk({tag, ".busy"}, 32'(nb), 32'(ecyc - 1));
    chk({tag, ".q"}, 32'(bus.Heresi), 32'(eq));
    chk({tag, ".r"}, 32'(bus.Mbetja), 32'(er));
    chk({tag, ".dz"}, 32'(bus.DivZero), 32'(edz));
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.Hyrja1 = '0;
    bus.Hyrja2 = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.Busy), 32'd0);
    chk("rst.done", 32'(bus.Done), 32'd0);
    chk("rst.q", 32'(bus.Heresi), 32'd0);
    chk("rst.r", 32'(bus.Mbetja), 32'd0);
    chk("rst.dz", 32'(bus.DivZero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic divide and hold in IDLE
    do_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    repeat (3) @(negedge clk);
    chk("hold.done", 32'(bus.Done), 32'd0);
    chk("hold.busy", 32'(bus.Busy), 32'd0);
    chk("hold.q", 32'(bus.Heresi), 32'd14);
    chk("hold.r", 32'(bus.Mbetja), 32'd2);

    // Boundaries
    do_div("dmax_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
    @(negedge clk);
    do_div("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17);
    @(negedge clk);
    do_div("dmax_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17);
    @(negedge clk);
    do_div("d0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 17);
    @(negedge clk);

    // Divide by zero, then a normal divide clears DivZero
    do_div("dz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    @(negedge clk);
    do_div("d10_3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 17);
    @(negedge clk);

    // Start and operand changes during CALC are ignored
    start_op(16'd1000, 16'd10);
    repeat (4) @(negedge clk);
    bus.Start  = 1'b1;
    bus.Hyrja1 = 16'd7;
    bus.Hyrja2 = 16'd2;
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.Hyrja1 = 16'd123;
    bus.Hyrja2 = 16'd0;
    wait_done(6, cyc, busy_n);
    chk("ign.lat", 32'(cyc), 32'd17);
    chk("ign.q", 32'(bus.Heresi), 32'd100);
    chk("ign.r", 32'(bus.Mbetja), 32'd0);
    @(negedge clk);
    chk("ign.once", 32'(bus.Done), 32'd0);

    // Back-to-back: Start held during the Done cycle
    do_div("b2b1", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    bus.Start  = 1'b1;
    bus.Hyrja1 = 16'd50;
    bus.Hyrja2 = 16'd6;
    @(negedge clk);
    bus.Start  = 1'b0;
    chk("b2b.busy", 32'(bus.Busy), 32'd1);
    chk("b2b.nodone", 32'(bus.Done), 32'd0);
    repeat (8) @(negedge clk);
    chk("b2b.holdq", 32'(bus.Heresi), 32'd14);
    chk("b2b.holdr", 32'(bus.Mbetja), 32'd2);
    wait_done(9, cyc, busy_n);
    chk("b2b.lat", 32'(cyc), 32'd17);
    chk("b2b.q", 32'(bus.Heresi), 32'd8);
    chk("b2b.r", 32'(bus.Mbetja), 32'd2);
    @(negedge clk);

    // Reset in the middle of CALC
    start_op(16'd300, 16'd7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.busy", 32'(bus.Busy), 32'd0);
    chk("mrst.done", 32'(bus.Done), 32'd0);
    chk("mrst.q", 32'(bus.Heresi), 32'd0);
    chk("mrst.r", 32'(bus.Mbetja), 32'd0);
    chk("mrst.dz", 32'(bus.DivZero), 32'd0);
    rst       = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) done_seen++;
    end
    chk("mrst.quiet", 32'(done_seen), 32'd0);
    do_div("d300_7", 16'd300, 16'd7, 16'd42, 16'd6, 1'b0, 17);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
